syn_fifo_module: RTL
====================

Name: syn_fifo_module

Overview:
Single-clock parametrised FIFO, successor to the team's dual-clock FIFO for same-domain buffering.
Adds selectable read mode (standard or first-word-fall-through), programmable almost-full/almost-empty thresholds, an occupancy count, and overflow/underflow error pulses.
Sits between same-clock producer and consumer stages in datapaths that need no clock-domain crossing.

Parameters:
P_DATA_WIDTH, 8, data word width in bits (>=1)
P_ADDR_DEPTH, 16, number of entries; power of 2, >=4
P_FWFT, 0, 0 = standard read (data one cycle after accepted read); 1 = first-word-fall-through
P_AFULL_TH, 14, o_afull asserted when count >= this value (1..P_ADDR_DEPTH)
P_AEMPTY_TH, 2, o_aempty asserted when count <= this value (0..P_ADDR_DEPTH-1)

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst_n  input  1  reset, asynchronous assert, active-low
i_wr_en  input  1  write request
i_wdata  input  P_DATA_WIDTH  write data
o_wfull  output  1  count == P_ADDR_DEPTH
o_afull  output  1  count >= P_AFULL_TH
i_rd_en  input  1  read request
o_rdata  output  P_DATA_WIDTH  read data
o_rempty  output  1  count == 0
o_aempty  output  1  count <= P_AEMPTY_TH
o_data_cnt  output  log2(P_ADDR_DEPTH)+1  current occupancy, 0..P_ADDR_DEPTH
o_overflow  output  1  one-cycle pulse: write request rejected
o_underflow  output  1  one-cycle pulse: read request rejected

Behaviour:
- Reset (i_rst_n=0, asynchronous): write/read pointers=0, count=0, o_rempty=1, o_aempty=1, o_wfull=0, o_afull=0, o_data_cnt=0, o_rdata=0, o_overflow=0, o_underflow=0. Storage array is not reset. Deassertion is sampled on the next i_clk rising edge.
- Write acceptance: wr_ok = i_wr_en && !o_wfull, using flag values current in that cycle. An accepted write stores i_wdata at the write pointer. The pointer increments modulo P_ADDR_DEPTH (natural wrap).
- Read acceptance: rd_ok = i_rd_en && !o_rempty. An accepted read advances the read pointer modulo P_ADDR_DEPTH.
- Count update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- Flags and o_data_cnt are derived from the registered count. They reflect an operation in the cycle after the edge that performed it.
- Simultaneous request when full: read accepted, write rejected, o_overflow pulses. Count ends at P_ADDR_DEPTH-1. No same-cycle pass-through.
- Simultaneous request when empty: write accepted, read rejected, o_underflow pulses. Count ends at 1.
- Simultaneous request at 0 < count < depth: both accepted, count unchanged.
- o_overflow = registered (i_wr_en && o_wfull). o_underflow = registered (i_rd_en && o_rempty). Each is high for exactly one cycle per rejected request.
- Standard mode (P_FWFT=0):
  - On rd_ok, o_rdata is loaded with the head word at that edge, so it is valid in the following cycle.
  - o_rdata holds its value when no read is accepted, including on a rejected read.
- FWFT mode (P_FWFT=1):
  - o_rdata continuously shows the head entry whenever o_rempty=0.
  - rd_ok pops the entry, and the next entry is shown in the following cycle.
  - A word written into an empty FIFO at edge N appears on o_rdata, with o_rempty=0, after edge N.
  - o_rdata is don't-care while o_rempty=1.
- Pointer wrap: sustained full-rate write/read across multiple depth wraps preserves order with no data loss.
- Reset mid-operation discards all contents immediately; the first post-reset read returns the first post-reset write.

Test Plan:
- Defaults, P_FWFT=0, write 0x01..0x10 on 16 consecutive cycles:
  - o_afull rises after the 14th write; o_wfull rises after the 16th; o_data_cnt=16.
  - A 17th write (0xAA) produces a 1-cycle o_overflow, and count stays 16.
- From full, read 16 cycles:
  - o_rdata shows 0x01..0x10, each one cycle after its accepted read.
  - o_aempty rises when count reaches 2; o_rempty rises after the 16th read.
  - A 17th read gives a 1-cycle o_underflow, and o_rdata holds 0x10.
- P_FWFT=1, write 0x5A into empty:
  - Next cycle o_rempty=0 and o_rdata=0x5A without i_rd_en.
  - Pulsing i_rd_en returns o_rempty to 1 and o_data_cnt to 0.
- Count=8, assert i_wr_en and i_rd_en together for 40 cycles with incrementing data:
  - Count stays 8 throughout; output sequence is strictly incrementing with no gaps across pointer wraps.
- Full FIFO, simultaneous wr+rd: count becomes 15 and o_overflow pulses. Empty FIFO, simultaneous wr+rd: count becomes 1 and o_underflow pulses.
- Write 5 words, drop i_rst_n mid-cycle:
  - Outputs reach reset values without waiting for a clock edge.
  - After release, writing 0x33 then reading returns 0x33.

Source files
------------

// File: rtl/syn_fifo_module.sv
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, occupancy count and overflow/underflow pulses.
module syn_fifo_module #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_DEPTH = 16,
    parameter int P_FWFT       = 0,
    parameter int P_AFULL_TH   = 14,
    parameter int P_AEMPTY_TH  = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_wr_en,
    input  logic [P_DATA_WIDTH-1:0]           i_wdata,
    output logic                              o_wfull,
    output logic                              o_afull,
    input  logic                              i_rd_en,
    output logic [P_DATA_WIDTH-1:0]           o_rdata,
    output logic                              o_rempty,
    output logic                              o_aempty,
    output logic [$clog2(P_ADDR_DEPTH):0]     o_data_cnt,
    output logic                              o_overflow,
    output logic                              o_underflow
);

    localparam int L_AW    = $clog2(P_ADDR_DEPTH);
    localparam int L_CNT_W = L_AW + 1;

    localparam logic [L_CNT_W-1:0] L_DEPTH     = L_CNT_W'(P_ADDR_DEPTH);
    localparam logic [L_CNT_W-1:0] L_AFULL_TH  = L_CNT_W'(P_AFULL_TH);
    localparam logic [L_CNT_W-1:0] L_AEMPTY_TH = L_CNT_W'(P_AEMPTY_TH);

    logic [P_DATA_WIDTH-1:0] r_mem [P_ADDR_DEPTH];
    logic [L_AW-1:0]         r_wptr;
    logic [L_AW-1:0]         r_rptr;
    logic [L_CNT_W-1:0]      r_cnt;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_ok;
    logic                    w_rd_ok;
    logic [P_DATA_WIDTH-1:0] w_head;
    logic [P_DATA_WIDTH-1:0] w_rdata;

    // Flags come straight from the registered count, so they trail the edge that changed it.
    assign w_full  = (r_cnt == L_DEPTH);
    assign w_empty = (r_cnt == '0);
    assign w_wr_ok = i_wr_en && !w_full;
    assign w_rd_ok = i_rd_en && !w_empty;
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + L_AW'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + L_AW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_cnt <= r_cnt + L_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - L_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= i_wr_en && w_full;
            r_underflow <= i_rd_en && w_empty;
        end
    end

    generate
        if (P_FWFT != 0) begin : g_fwft
            // Head is shown combinationally; forced to zero while empty so reset reads back 0.
            assign w_rdata = w_empty ? '0 : w_head;
        end else begin : g_std
            logic [P_DATA_WIDTH-1:0] r_rdata;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rdata <= '0;
                end else if (w_rd_ok) begin
                    r_rdata <= w_head;
                end
            end

            assign w_rdata = r_rdata;
        end
    endgenerate

    assign o_rdata     = w_rdata;
    assign o_wfull     = w_full;
    assign o_rempty    = w_empty;
    assign o_afull     = (r_cnt >= L_AFULL_TH);
    assign o_aempty    = (r_cnt <= L_AEMPTY_TH);
    assign o_data_cnt  = r_cnt;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule
